fifo_push_packer: RTL and testbench
===================================

Name: fifo_push_packer

Overview:
- Upstream feeder for the overflow FIFO. Gathers narrow IN_W beats into one IN_W*RATIO word and issues a single-cycle push, laid out to match the FIFO's push_data/push inputs.
- The FIFO never back-pressures, because it drops its oldest entry when full. This block therefore has no ready signal.
- Emits partial words on an explicit last beat or after an idle timeout. Supports a flush that discards any partial word.

Parameters:
- IN_W, 8, width of one input beat.
- RATIO, 4, beats per packed word (≥2); output width is IN_W*RATIO.
- TIMEOUT, 16, idle cycles with a partial word held before it is pushed (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard partial word and cancel pending push.
- in_data  in  IN_W  input beat.
- in_valid  in  1  beat accepted this cycle; always accepted, no ready.
- in_last  in  1  qualified by in_valid; closes the word with this beat.
- push_data  out  IN_W*RATIO  packed word to FIFO push_data.
- push  out  1  one-cycle push strobe to FIFO push.
- push_beats  out  $clog2(RATIO+1)  number of valid beats in push_data (1..RATIO); 0 when push low.

Behaviour:
- Reset (rst_n low, async): push=0, push_data=0, push_beats=0, beat count=0, idle counter=0, state IDLE.
- Packing order: beat k of a word goes to bits [k*IN_W +: IN_W], first beat in the LSBs. Lanes not filled in a pushed word are zero.
- States:
  - IDLE: no beats held. in_valid moves to FILL with count=1.
  - FILL: 1..RATIO-1 beats held.
- Word closes on:
  - the in_valid beat that brings count to RATIO;
  - an in_valid & in_last beat (any count);
  - idle counter reaching TIMEOUT while in FILL.
- On close: push=1 on the next cycle, a registered output with latency 1. push_data and push_beats are valid in that same cycle. State returns to IDLE with count=0.
- Back-to-back: a beat arriving in the cycle push is high starts a new word. Full-rate input gives one push every RATIO cycles with no lost beats.
- in_valid & in_last on the first beat in IDLE gives push_beats=1.
- Idle counter:
  - clears on any in_valid and in IDLE;
  - increments each FILL cycle without in_valid;
  - at TIMEOUT the partial word is closed.
  - A beat arriving in the same cycle the counter reaches TIMEOUT takes priority: the beat is appended and the counter clears; no timeout close that cycle.
- flush (synchronous, highest priority):
  - Clears count, idle counter and state to IDLE.
  - The in_valid beat of that same cycle is dropped.
  - push is forced to 0 on the next cycle, even if a close occurred in the flush cycle.
  - A push already high in the flush cycle completes; the FIFO flushes concurrently.
- push is never high for two consecutive cycles unless RATIO beats, or a last/timeout close, occurred in between.
- Reset asserted mid-word drops the partial word with no push.

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined: adds outputs partial_pushes[15:0] and dropped_beats[15:0], both saturating at 16'hFFFF and reset to 0.
  - partial_pushes increments on each push with push_beats<RATIO.
  - dropped_beats adds the held beat count, plus 1 if in_valid, on each flush.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- RATIO=4, IN_W=8, beats 0x11,0x22,0x33,0x44 on consecutive cycles → cycle after 0x44: push=1, push_data=0x44332211, push_beats=4. push is 0 in all other cycles.
- 8 continuous beats 0x01..0x08 → pushes 0x04030201 and 0x08070605 exactly 4 cycles apart, each with push_beats=4.
- Beats 0xAA,0xBB with in_last on 0xBB → next cycle push_data=0x0000BBAA, push_beats=2. A following beat 0xCC starts a fresh word.
- Single beat 0x5A, then idle with TIMEOUT=16 → push on cycle 17 after the beat with push_data=0x0000005A, push_beats=1. A beat at idle cycle 16 instead extends the word and gives no push.
- Three beats, then flush together with a fourth beat → no push ever. The next 4 beats produce a clean word; with PACKER_STATS_EN, dropped_beats=4.
- rst_n pulsed low mid-word after 2 beats → push=0 immediately and stays 0. The next 4 beats give a correct full word.

Source files
------------

// File: rtl/fifo_push_packer.sv
// Packs IN_W-bit beats into one IN_W*RATIO-bit word and issues a single-cycle push to the
// overflow FIFO. Words close on RATIO beats, an in_last beat, or an idle timeout.
// Optional counters (partial_pushes, dropped_beats) are built when PACKER_STATS_EN is defined.
module fifo_push_packer #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic [IN_W*RATIO-1:0]         push_data,
  output logic                          push,
  output logic [$clog2(RATIO+1)-1:0]    push_beats
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]                   partial_pushes,
  output logic [15:0]                   dropped_beats
`endif
);

  localparam int unsigned OutW  = IN_W * RATIO;
  localparam int unsigned CntW  = $clog2(RATIO + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [OutW-1:0] buf_q, buf_d;
  logic [OutW-1:0] merged;
  logic            push_q, push_d;
  logic [OutW-1:0] push_data_q, push_data_d;
  logic [CntW-1:0] push_beats_q, push_beats_d;

  // Held word with the incoming beat dropped into the lane selected by the current count.
  always_comb begin
    merged = buf_q;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (count_q == CntW'(k)) begin
        merged[k*IN_W +: IN_W] = in_data;
      end
    end
  end

  // Next-state: flush beats everything, then an accepted beat, then the idle timeout.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idle_d       = idle_q;
    buf_d        = buf_q;
    push_d       = 1'b0;
    push_data_d  = '0;
    push_beats_d = '0;
    if (flush) begin
      // Drops the held word, this cycle's beat, and any close decided this cycle.
      state_d = StIdle;
      count_d = '0;
      idle_d  = '0;
      buf_d   = '0;
    end else if (in_valid) begin
      idle_d = '0;
      if (in_last || (count_q == CntW'(RATIO - 1))) begin
        push_d       = 1'b1;
        push_data_d  = merged;
        push_beats_d = count_q + CntW'(1);
        state_d      = StIdle;
        count_d      = '0;
        buf_d        = '0;
      end else begin
        state_d = StFill;
        count_d = count_q + CntW'(1);
        buf_d   = merged;
      end
    end else if (state_q == StFill) begin
      if (idle_q == IdleW'(TIMEOUT)) begin
        push_d       = 1'b1;
        push_data_d  = buf_q;
        push_beats_d = count_q;
        state_d      = StIdle;
        count_d      = '0;
        idle_d       = '0;
        buf_d        = '0;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  // State and registered push outputs; reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      idle_q       <= '0;
      buf_q        <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_beats_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      buf_q        <= buf_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      push_beats_q <= push_beats_d;
    end
  end

  assign push       = push_q;
  assign push_data  = push_data_q;
  assign push_beats = push_beats_q;

`ifdef PACKER_STATS_EN
  logic [15:0] partial_q;
  logic [15:0] dropped_q;
  logic [16:0] drop_sum;

  // Beats lost to a flush: those held plus the beat arriving with the flush.
  always_comb begin
    drop_sum = {1'b0, dropped_q} + 17'(count_q) + 17'(in_valid);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial_q <= '0;
      dropped_q <= '0;
    end else begin
      if (push_q && (push_beats_q != CntW'(RATIO)) && (partial_q != 16'hFFFF)) begin
        partial_q <= partial_q + 16'd1;
      end
      if (flush) begin
        dropped_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  assign partial_pushes = partial_q;
  assign dropped_beats  = dropped_q;
`endif

endmodule

// File: tb/tb_fifo_push_packer.sv
// Directed self-checking bench for fifo_push_packer (IN_W=8, RATIO=4, TIMEOUT=16).
module tb_fifo_push_packer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic [31:0] push_data;
  logic        push;
  logic [2:0]  push_beats;
`ifdef PACKER_STATS_EN
  logic [15:0] partial_pushes;
  logic [15:0] dropped_beats;
`endif

  int errors = 0;
  int checks = 0;

  fifo_push_packer #(
    .IN_W   (8),
    .RATIO  (4),
    .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .push_data (push_data),
    .push      (push),
    .push_beats(push_beats)
`ifdef PACKER_STATS_EN
    ,
    .partial_pushes(partial_pushes),
    .dropped_beats (dropped_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle.
  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (push !== 1'b0) begin
      errors++; $display("FAIL reset_push: got %b expected 0", push);
    end
    checks++;
    if (push_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", push_data);
    end
    checks++;
    if (push_beats !== 3'd0) begin
      errors++; $display("FAIL reset_beats: got %0d expected 0", push_beats);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_word();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 3; i++) begin
      beat(vals[i], 1'b0);
      checks++;
      if (push !== 1'b0) begin
        errors++; $display("FAIL full_nopush%0d: got %b expected 0", i, push);
      end
    end
    beat(vals[3], 1'b0);
    checks++;
    if (push !== 1'b1 || push_data !== 32'h44332211 || push_beats !== 3'd4) begin
      errors++;
      $display("FAIL full_word: got push=%b data=%h beats=%0d expected 1 44332211 4",
               push, push_data, push_beats);
    end
    step();
    checks++;
    if (push !== 1'b0 || push_beats !== 3'd0) begin
      errors++; $display("FAIL full_after: got push=%b beats=%0d expected 0 0", push, push_beats);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_word;
    for (int i = 0; i < 8; i++) begin
      beat(8'(i + 1), 1'b0);
      checks++;
      if (i % 4 == 3) begin
        exp_word = (i == 3) ? 32'h04030201 : 32'h08070605;
        if (push !== 1'b1 || push_data !== exp_word || push_beats !== 3'd4) begin
          errors++;
          $display("FAIL b2b_push%0d: got push=%b data=%h beats=%0d expected 1 %h 4",
                   i, push, push_data, push_beats, exp_word);
        end
      end else if (push !== 1'b0) begin
        errors++; $display("FAIL b2b_gap%0d: got push=%b expected 0", i, push);
      end
    end
    step();
    checks++;
    if (push !== 1'b0) begin
      errors++; $display("FAIL b2b_after: got %b expected 0", push);
    end
  endtask

  task automatic test_last();
    beat(8'hAA, 1'b0);
    checks++;
    if (push !== 1'b0) begin
      errors++; $display("FAIL last_early: got %b expected 0", push);
    end
    beat(8'hBB, 1'b1);
    checks++;
    if (push !== 1'b1 || push_data !== 32'h0000BBAA || push_beats !== 3'd2) begin
      errors++;
      $display("FAIL last_word: got push=%b data=%h beats=%0d expected 1 0000bbaa 2",
               push, push_data, push_beats);
    end
    // New word begins while the previous push is high.
    beat(8'hCC, 1'b0);
    checks++;
    if (push !== 1'b0) begin
      errors++; $display("FAIL last_fresh_gap: got %b expected 0", push);
    end
    beat(8'hDD, 1'b1);
    checks++;
    if (push !== 1'b1 || push_data !== 32'h0000DDCC || push_beats !== 3'd2) begin
      errors++;
      $display("FAIL last_fresh: got push=%b data=%h beats=%0d expected 1 0000ddcc 2",
               push, push_data, push_beats);
    end
    step();
  endtask

  task automatic test_timeout();
    int early;
    beat(8'h5A, 1'b0);
    early = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (push !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL timeout_early: got %0d early pushes expected 0", early);
    end
    step();
    checks++;
    if (push !== 1'b1 || push_data !== 32'h0000005A || push_beats !== 3'd1) begin
      errors++;
      $display("FAIL timeout_word: got push=%b data=%h beats=%0d expected 1 0000005a 1",
               push, push_data, push_beats);
    end
    step();
    checks++;
    if (push !== 1'b0) begin
      errors++; $display("FAIL timeout_after: got %b expected 0", push);
    end
    // A beat in the cycle the counter reaches TIMEOUT extends the word.
    beat(8'h5A, 1'b0);
    for (int k = 1; k <= 16; k++) step();
    beat(8'h6B, 1'b0);
    early = 0;
    for (int k = 0; k < 5; k++) begin
      if (push !== 1'b0) early++;
      step();
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL timeout_extend: got %0d pushes expected 0", early);
    end
    beat(8'h7C, 1'b1);
    checks++;
    if (push !== 1'b1 || push_data !== 32'h007C6B5A || push_beats !== 3'd3) begin
      errors++;
      $display("FAIL timeout_ext_word: got push=%b data=%h beats=%0d expected 1 007c6b5a 3",
               push, push_data, push_beats);
    end
    step();
  endtask

  task automatic test_flush();
    int seen;
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b0);
    flush = 1'b1;
    beat(8'h40, 1'b0);
    flush = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (push !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_nopush: got %0d pushes expected 0", seen);
    end
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b0);
    beat(8'hA4, 1'b0);
    checks++;
    if (push !== 1'b1 || push_data !== 32'hA4A3A2A1 || push_beats !== 3'd4) begin
      errors++;
      $display("FAIL flush_clean: got push=%b data=%h beats=%0d expected 1 a4a3a2a1 4",
               push, push_data, push_beats);
    end
    step();
`ifdef PACKER_STATS_EN
    checks++;
    if (dropped_beats !== 16'd4) begin
      errors++; $display("FAIL stats_dropped: got %0d expected 4", dropped_beats);
    end
    checks++;
    if (partial_pushes !== 16'd4) begin
      errors++; $display("FAIL stats_partial: got %0d expected 4", partial_pushes);
    end
`endif
  endtask

  task automatic test_reset_midword();
    int seen;
    beat(8'hE1, 1'b0);
    beat(8'hE2, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (push !== 1'b0 || push_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_now: got push=%b data=%h expected 0 0", push, push_data);
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (push !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_mid_stay: got %0d pushes expected 0", seen);
    end
    beat(8'hD1, 1'b0);
    beat(8'hD2, 1'b0);
    beat(8'hD3, 1'b0);
    beat(8'hD4, 1'b0);
    checks++;
    if (push !== 1'b1 || push_data !== 32'hD4D3D2D1 || push_beats !== 3'd4) begin
      errors++;
      $display("FAIL rst_mid_word: got push=%b data=%h beats=%0d expected 1 d4d3d2d1 4",
               push, push_data, push_beats);
    end
    step();
`ifdef PACKER_STATS_EN
    checks++;
    if (dropped_beats !== 16'd0) begin
      errors++; $display("FAIL stats_reset: got %0d expected 0", dropped_beats);
    end
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    test_reset();
    test_full_word();
    test_back_to_back();
    test_last();
    test_timeout();
    test_flush();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
